control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_pkg.sv | 46 ++++
 rtl/control_unit_if.sv | 41 ++++
 rtl/instr_decoder.sv | 47 ++++
 rtl/control_unit.sv | 83 ++++++++
 tb/tb_control_unit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/control_unit_pkg.sv
// ============================================================================
// Module   : control_unit_pkg
// Purpose  : Shared FSM states, instruction classes and RV64I field encodings
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package control_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_ERROR     = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_ADD  = 3'd1,
        CLS_SUB  = 3'd2,
        CLS_ADDI = 3'd3,
        CLS_LD   = 3'd4,
        CLS_SD   = 3'd5
    } instr_class_t;

    localparam logic [6:0] c_OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] c_OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPCODE_STORE  = 7'b0100011;

    localparam logic [2:0] c_FUNCT3_ADD    = 3'b000;
    localparam logic [2:0] c_FUNCT3_DOUBLE = 3'b011;

    localparam logic [6:0] c_FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] c_FUNCT7_ALT    = 7'b0100000;

    function automatic logic usesImmediate(input instr_class_t cls);
        return (cls == CLS_ADDI) || (cls == CLS_LD) || (cls == CLS_SD);
    endfunction

endpackage

`default_nettype wire

// File: rtl/control_unit_if.sv
// ============================================================================
// Module   : control_unit_if
// Purpose  : Run/instruction inputs and datapath control strobes of the unit
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface control_unit_if #(
    parameter int COUNT_WIDTH = 32
) ();

    logic                   run;
    logic [31:0]            instruction;
    logic                   irWrite;
    logic                   pcWrite;
    logic                   writeEnable_Registers;
    logic                   writeEnable_DataMemory;
    logic                   muxSelect_ImmVsDataout2;
    logic                   muxSelect_SumVsReadData;
    logic                   SumOrSub;
    logic                   busy;
    logic                   illegal;
    logic [COUNT_WIDTH-1:0] retiredCount;

    modport master (
        output run, instruction,
        input  irWrite, pcWrite, writeEnable_Registers, writeEnable_DataMemory,
               muxSelect_ImmVsDataout2, muxSelect_SumVsReadData, SumOrSub,
               busy, illegal, retiredCount
    );

    modport slave (
        input  run, instruction,
        output irWrite, pcWrite, writeEnable_Registers, writeEnable_DataMemory,
               muxSelect_ImmVsDataout2, muxSelect_SumVsReadData, SumOrSub,
               busy, illegal, retiredCount
    );

endinterface

`default_nettype wire

// File: rtl/instr_decoder.sv
// ============================================================================
// Module   : instr_decoder
// Purpose  : Combinational classifier for the supported instruction subset
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_decoder
    import control_unit_pkg::*;
(
    input  wire logic [31:0] instruction,
    output instr_class_t     instrClass,
    output logic             valid
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_unusedFields;

    assign w_opcode       = instruction[6:0];
    assign w_funct3       = instruction[14:12];
    assign w_funct7       = instruction[31:25];
    // Register and immediate fields only matter to the datapath.
    assign w_unusedFields = ^{instruction[24:15], instruction[11:7]};

    always_comb begin
        instrClass = CLS_NONE;
        if (w_opcode == c_OPCODE_OP && w_funct3 == c_FUNCT3_ADD) begin
            if (w_funct7 == c_FUNCT7_BASE)
                instrClass = CLS_ADD;
            else if (w_funct7 == c_FUNCT7_ALT)
                instrClass = CLS_SUB;
        end else if (w_opcode == c_OPCODE_OP_IMM && w_funct3 == c_FUNCT3_ADD) begin
            instrClass = CLS_ADDI;
        end else if (w_opcode == c_OPCODE_LOAD && w_funct3 == c_FUNCT3_DOUBLE) begin
            instrClass = CLS_LD;
        end else if (w_opcode == c_OPCODE_STORE && w_funct3 == c_FUNCT3_DOUBLE) begin
            instrClass = CLS_SD;
        end
    end

    assign valid = (instrClass != CLS_NONE);

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// Module   : control_unit
// Purpose  : Multi-cycle Moore control FSM with retired-instruction counter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit
    import control_unit_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    control_unit_if.slave bus
);

    state_t                 r_state;
    state_t                 w_stateNext;
    instr_class_t           r_class;
    instr_class_t           w_decClass;
    logic                   w_decValid;
    logic                   w_retire;
    logic                   w_datapathActive;
    logic [COUNT_WIDTH-1:0] r_retiredCount;

    instr_decoder u_decoder (
        .instruction (bus.instruction),
        .instrClass  (w_decClass),
        .valid       (w_decValid)
    );

    always_comb begin
        w_stateNext = r_state;
        w_retire    = 1'b0;
        case (r_state)
            ST_IDLE:      if (bus.run) w_stateNext = ST_FETCH;
            ST_FETCH:     w_stateNext = ST_DECODE;
            ST_DECODE:    w_stateNext = w_decValid ? ST_EXECUTE : ST_ERROR;
            ST_EXECUTE:   w_stateNext = (r_class == CLS_LD || r_class == CLS_SD)
                                        ? ST_MEM : ST_WRITEBACK;
            ST_MEM:       if (r_class == CLS_SD) w_retire = 1'b1;
                          else w_stateNext = ST_WRITEBACK;
            ST_WRITEBACK: w_retire = 1'b1;
            ST_ERROR:     w_stateNext = ST_ERROR;
            default:      w_stateNext = ST_IDLE;
        endcase
        // run is only honoured at instruction boundaries.
        if (w_retire)
            w_stateNext = bus.run ? ST_FETCH : ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_class        <= CLS_NONE;
            r_retiredCount <= '0;
        end else begin
            r_state <= w_stateNext;
            if (r_state == ST_DECODE)
                r_class <= w_decClass;
            if (w_retire)
                r_retiredCount <= r_retiredCount + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign w_datapathActive = (r_state == ST_EXECUTE) || (r_state == ST_MEM) ||
                              (r_state == ST_WRITEBACK);

    assign bus.irWrite                 = (r_state == ST_FETCH);
    assign bus.pcWrite                 = (r_state == ST_FETCH);
    assign bus.writeEnable_Registers   = (r_state == ST_WRITEBACK);
    assign bus.writeEnable_DataMemory  = (r_state == ST_MEM) && (r_class == CLS_SD);
    assign bus.muxSelect_ImmVsDataout2 = w_datapathActive && usesImmediate(r_class);
    assign bus.muxSelect_SumVsReadData = w_datapathActive && (r_class == CLS_LD);
    assign bus.SumOrSub                = w_datapathActive && (r_class == CLS_SUB);
    assign bus.busy                    = (r_state != ST_IDLE) && (r_state != ST_ERROR);
    assign bus.illegal                 = (r_state == ST_ERROR);
    assign bus.retiredCount            = r_retiredCount;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module   : tb_control_unit
// Purpose  : Scoreboard bench: stimulus queues per-cycle expectations, monitor compares
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

    localparam int CW = 8;

    // Flag vector: {irWrite, pcWrite, weReg, weMem, imm, sumRead, sub, busy, illegal}
    localparam logic [8:0] F_IDLE   = 9'b000000000;
    localparam logic [8:0] F_FETCH  = 9'b110000010;
    localparam logic [8:0] F_DECODE = 9'b000000010;
    localparam logic [8:0] F_ERR    = 9'b000000001;
    localparam logic [8:0] ADD_EX   = 9'b000000010;
    localparam logic [8:0] ADD_WB   = 9'b001000010;
    localparam logic [8:0] SUB_EX   = 9'b000000110;
    localparam logic [8:0] SUB_WB   = 9'b001000110;
    localparam logic [8:0] ADDI_EX  = 9'b000010010;
    localparam logic [8:0] ADDI_WB  = 9'b001010010;
    localparam logic [8:0] LD_EX    = 9'b000011010;
    localparam logic [8:0] LD_MEM   = 9'b000011010;
    localparam logic [8:0] LD_WB    = 9'b001011010;
    localparam logic [8:0] SD_EX    = 9'b000010010;
    localparam logic [8:0] SD_MEM   = 9'b000110010;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LD   = 32'h0080B283;
    localparam logic [31:0] I_SD   = 32'h0020B823;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

    typedef struct packed {
        int              cyc;
        logic [8:0]      flags;
        logic [CW-1:0]   count;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   nChecks = 0;
    int   nFails = 0;
    logic [CW-1:0] expCount = '0;
    exp_t  sb[$];
    string sbName[$];

    control_unit_if #(.COUNT_WIDTH(CW)) bus ();

    control_unit #(.COUNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] actFlags();
        return {bus.irWrite, bus.pcWrite, bus.writeEnable_Registers,
                bus.writeEnable_DataMemory, bus.muxSelect_ImmVsDataout2,
                bus.muxSelect_SumVsReadData, bus.SumOrSub, bus.busy, bus.illegal};
    endfunction

    task automatic checkVec(input string nm, input logic [8:0] expF, input logic [CW-1:0] expC);
        logic [8:0] a;
        a = actFlags();
        nChecks++;
        if (a !== expF || bus.retiredCount !== expC) begin
            nFails++;
            $display("FAIL %s @cyc %0d: got flags=%b count=%0d, expected flags=%b count=%0d",
                     nm, cyc, a, bus.retiredCount, expF, expC);
        end
    endtask

    task automatic push(input int c, input logic [8:0] f, input string nm);
        exp_t e;
        e.cyc   = c;
        e.flags = f;
        e.count = expCount;
        sb.push_back(e);
        sbName.push_back(nm);
    endtask

    // Monitor: compares every expectation queued for the current cycle.
    always @(negedge clk) begin
        exp_t  e;
        string nm;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e  = sb.pop_front();
            nm = sbName.pop_front();
            if (e.cyc < cyc) begin
                nChecks++;
                nFails++;
                $display("FAIL %s: entry for cycle %0d not checked, now cycle %0d", nm, e.cyc, cyc);
            end else begin
                checkVec(nm, e.flags, e.count);
            end
        end
    end

    task automatic idleCycles(input int k);
        bus.run = 1'b0;
        for (int i = 1; i <= k; i++) push(cyc + i, F_IDLE, "idle");
        repeat (k) begin @(posedge clk); #1; end
    endtask

    task automatic issue(input logic [31:0] instr, input logic [8:0] ex,
                         input logic [8:0] mem, input bit hasMem,
                         input logic [8:0] wb, input bit hasWb,
                         input bit runAfter, input bit dropMid, input string nm);
        int n;
        int k;
        n = cyc;
        bus.run = 1'b1;
        bus.instruction = instr;
        push(n + 1, F_FETCH,  {nm, ":fetch"});
        push(n + 2, F_DECODE, {nm, ":decode"});
        push(n + 3, ex,       {nm, ":execute"});
        k = 4;
        if (hasMem) begin push(n + k, mem, {nm, ":mem"}); k++; end
        if (hasWb)  begin push(n + k, wb,  {nm, ":writeback"}); k++; end
        for (int i = 1; i <= k - 1; i++) begin
            @(posedge clk); #1;
            if (i == 3) begin
                // Past DECODE: a changed instruction must not matter.
                bus.instruction = I_BAD;
                if (dropMid) bus.run = 1'b0;
            end
        end
        bus.run = runAfter && !dropMid;
        expCount = expCount + 1'b1;
    endtask

    task automatic issueIllegal(input logic [31:0] instr, input int errCycles);
        int n;
        n = cyc;
        bus.run = 1'b1;
        bus.instruction = instr;
        push(n + 1, F_FETCH,  "illegal:fetch");
        push(n + 2, F_DECODE, "illegal:decode");
        for (int j = 3; j <= 2 + errCycles; j++) push(n + j, F_ERR, "illegal:error_hold");
        repeat (2 + errCycles) begin @(posedge clk); #1; end
    endtask

    task automatic ldResetMidMem();
        int n;
        n = cyc;
        bus.run = 1'b1;
        bus.instruction = I_LD;
        push(n + 1, F_FETCH,  "ldrst:fetch");
        push(n + 2, F_DECODE, "ldrst:decode");
        push(n + 3, LD_EX,    "ldrst:execute");
        repeat (3) begin @(posedge clk); #1; end
        @(posedge clk); #2;
        checkVec("ldrst:mem_before_reset", LD_MEM, expCount);
        #1 rst_n = 1'b0;
        expCount = '0;
        push(cyc, F_IDLE, "ldrst:held_in_reset");
        #1 checkVec("ldrst:async_reset", F_IDLE, '0);
        bus.run = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.run = 1'b0;
        bus.instruction = '0;
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        checkVec("reset_state", F_IDLE, '0);
        bus.run = 1'b1;
        @(posedge clk); #1;
        checkVec("run_ignored_in_reset", F_IDLE, '0);
        bus.run = 1'b0;
        rst_n = 1'b1;
        idleCycles(2);

        issue(I_ADD, ADD_EX, F_IDLE, 1'b0, ADD_WB, 1'b1, 1'b0, 1'b0, "add");
        idleCycles(2);

        issue(I_SUB,  SUB_EX,  F_IDLE, 1'b0, SUB_WB,  1'b1, 1'b1, 1'b0, "sub");
        issue(I_ADDI, ADDI_EX, F_IDLE, 1'b0, ADDI_WB, 1'b1, 1'b1, 1'b0, "addi");
        issue(I_LD,   LD_EX,   LD_MEM, 1'b1, LD_WB,   1'b1, 1'b1, 1'b0, "ld");
        issue(I_SD,   SD_EX,   SD_MEM, 1'b1, F_IDLE,  1'b0, 1'b1, 1'b1, "sd_drop_run");
        idleCycles(2);

        ldResetMidMem();
        idleCycles(2);

        issue(I_ADDI, ADDI_EX, F_IDLE, 1'b0, ADDI_WB, 1'b1, 1'b1, 1'b0, "addi2");
        issueIllegal(I_BAD, 20);

        @(negedge clk); #1;
        rst_n = 1'b0;
        expCount = '0;
        #1 checkVec("error_async_reset", F_IDLE, '0);
        bus.run = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idleCycles(2);

        @(negedge clk); #1;
        nChecks++;
        if (sb.size() != 0) begin
            nFails++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

`default_nettype wire
